// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared word and RAM-status types for the memory system
// Revision      : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

`default_nettype wire

// File: rtl/memory_arbiter_if.sv
// ============================================================================
// memory_arbiter_if : cache request/wait buses plus the RAM port
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface memory_arbiter_if #(
  parameter int ERRCNT_W = 8
);
  import cpu_types_pkg::*;

  logic                iREN;
  word_t               iaddr;
  logic                iwait;
  word_t               iload;
  logic                dREN;
  logic                dWEN;
  word_t               daddr;
  word_t               dstore;
  logic                dwait;
  word_t               dload;
  logic                ramREN;
  logic                ramWEN;
  word_t               ramaddr;
  word_t               ramstore;
  word_t               ramload;
  ramstate_t           ramstate;
  logic [ERRCNT_W-1:0] ramerr_cnt;

  // Arbiter side: responder to both caches, initiator towards RAM
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr_cnt
  );

  // Environment side: caches and RAM together
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr_cnt
  );

endinterface

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter : single-port RAM controller, data priority with I-starvation bound
// Revision       : 1.0
// ============================================================================
`default_nettype none

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ERRCNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

  localparam logic [ERRCNT_W-1:0] ERR_ONE = ERRCNT_W'(1);

  arb_state_t          state_q, state_d;
  logic [3:0]          dstreak_q, dstreak_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic [ERRCNT_W-1:0] errcnt_inc;
  logic                data_req;
  logic                starve_hit;

  always_comb begin
    data_req   = bus.dREN | bus.dWEN;
    starve_hit = (dstreak_q == 4'(STARVE_MAX));
    errcnt_inc = (errcnt_q == '1) ? errcnt_q : errcnt_q + ERR_ONE;

    state_d      = state_q;
    dstreak_d    = dstreak_q;
    errcnt_d     = errcnt_q;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      IDLE: begin
        if (!bus.iREN) dstreak_d = '0;
        // A pending instruction only overrides data once the streak bound is hit
        if (data_req && !(starve_hit && bus.iREN)) begin
          state_d = GRANT_D;
          if (bus.iREN) dstreak_d = dstreak_q + 4'd1;
        end else if (bus.iREN) begin
          state_d   = GRANT_I;
          dstreak_d = '0;
        end
      end

      GRANT_D: begin
        if (!data_req) begin
          state_d = IDLE;
        end else begin
          bus.ramaddr = bus.daddr;
          if (bus.dWEN) begin
            bus.ramWEN   = 1'b1;
            bus.ramstore = bus.dstore;
          end else begin
            bus.ramREN = 1'b1;
          end
          case (bus.ramstate)
            ACCESS: begin
              bus.dwait = 1'b0;
              if (!bus.dWEN) bus.dload = bus.ramload;
              state_d = IDLE;
            end
            ERROR:   errcnt_d = errcnt_inc;
            default: ;
          endcase
        end
      end

      GRANT_I: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          case (bus.ramstate)
            ACCESS: begin
              bus.iwait = 1'b0;
              bus.iload = bus.ramload;
              state_d   = IDLE;
            end
            ERROR:   errcnt_d = errcnt_inc;
            default: ;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ramerr_cnt = errcnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      errcnt_q  <= errcnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// tb_memory_arbiter : directed self-checking bench for memory_arbiter
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic RST;
  int   tests_run;
  int   tests_failed;
  int   ncomp;
  int   clash;
  logic [7:0] pat;

  memory_arbiter_if #(.ERRCNT_W(8)) bus ();

  memory_arbiter #(.STARVE_MAX(4), .ERRCNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST          = 1'b1;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;

    // Reset values
    cyc(); cyc(); #1;
    check("rst_iwait",   32'(bus.iwait),      32'd1);
    check("rst_dwait",   32'(bus.dwait),      32'd1);
    check("rst_iload",   bus.iload,           32'd0);
    check("rst_dload",   bus.dload,           32'd0);
    check("rst_ramREN",  32'(bus.ramREN),     32'd0);
    check("rst_ramWEN",  32'(bus.ramWEN),     32'd0);
    check("rst_ramaddr", bus.ramaddr,         32'd0);
    check("rst_errcnt",  32'(bus.ramerr_cnt), 32'd0);
    RST = 1'b0;

    // Data read, RAM ready on the first grant cycle
    cyc();
    bus.dREN = 1'b1; bus.daddr = 32'h40;
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    #1;
    check("rd_c1_ramREN", 32'(bus.ramREN), 32'd0);
    check("rd_c1_dwait",  32'(bus.dwait),  32'd1);
    cyc(); #1;
    check("rd_c2_dwait",   32'(bus.dwait),  32'd0);
    check("rd_c2_dload",   bus.dload,       32'hDEADBEEF);
    check("rd_c2_ramREN",  32'(bus.ramREN), 32'd1);
    check("rd_c2_ramWEN",  32'(bus.ramWEN), 32'd0);
    check("rd_c2_ramaddr", bus.ramaddr,     32'h40);
    check("rd_c2_iwait",   32'(bus.iwait),  32'd1);
    cyc();
    bus.dREN = 1'b0;
    #1;
    check("rd_idle_dwait",  32'(bus.dwait),  32'd1);
    check("rd_idle_ramREN", 32'(bus.ramREN), 32'd0);

    // Simultaneous instruction read and data write: data goes first
    cyc();
    bus.iREN = 1'b1; bus.iaddr = 32'h100;
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
    bus.ramload = 32'hCAFEF00D;
    cyc(); #1;
    check("sim_d_ramWEN",   32'(bus.ramWEN), 32'd1);
    check("sim_d_ramREN",   32'(bus.ramREN), 32'd0);
    check("sim_d_ramaddr",  bus.ramaddr,     32'h200);
    check("sim_d_ramstore", bus.ramstore,    32'h12345678);
    check("sim_d_dwait",    32'(bus.dwait),  32'd0);
    check("sim_d_dload",    bus.dload,       32'd0);
    check("sim_d_iwait",    32'(bus.iwait),  32'd1);
    bus.dWEN = 1'b0;
    cyc(); #1;
    check("sim_idle_ramREN", 32'(bus.ramREN), 32'd0);
    check("sim_idle_iwait",  32'(bus.iwait),  32'd1);
    cyc(); #1;
    check("sim_i_ramREN",  32'(bus.ramREN), 32'd1);
    check("sim_i_ramaddr", bus.ramaddr,     32'h100);
    check("sim_i_iwait",   32'(bus.iwait),  32'd0);
    check("sim_i_iload",   bus.iload,       32'hCAFEF00D);
    check("sim_i_dwait",   32'(bus.dwait),  32'd1);
    bus.iREN = 1'b0;

    // Starvation bound: four data words, one instruction word, data resumes
    cyc();
    bus.dREN = 1'b1; bus.daddr = 32'h600;
    bus.iREN = 1'b1; bus.iaddr = 32'h700;
    ncomp = 0; clash = 0; pat = '0;
    for (int k = 0; k < 11; k++) begin
      cyc(); #1;
      if (!bus.dwait) begin pat = {pat[6:0], 1'b0}; ncomp++; end
      if (!bus.iwait) begin pat = {pat[6:0], 1'b1}; ncomp++; end
      if (!bus.dwait && !bus.iwait) clash++;
    end
    check("starve_count", 32'(ncomp), 32'd6);
    check("starve_order", 32'(pat),   32'h02);
    check("starve_clash", 32'(clash), 32'd0);
    cyc();
    bus.dREN = 1'b0; bus.iREN = 1'b0;

    // Three ERROR cycles then ACCESS on a data read
    cyc();
    bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = ERROR;
    #1;
    check("err_cnt_start", 32'(bus.ramerr_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      check("err_hold_ramREN",  32'(bus.ramREN), 32'd1);
      check("err_hold_ramaddr", bus.ramaddr,     32'h80);
      check("err_hold_dwait",   32'(bus.dwait),  32'd1);
    end
    cyc();
    bus.ramstate = ACCESS; bus.ramload = 32'h55AA55AA;
    #1;
    check("err_done_dwait",  32'(bus.dwait),      32'd0);
    check("err_done_dload",  bus.dload,           32'h55AA55AA);
    check("err_done_ramREN", 32'(bus.ramREN),     32'd1);
    check("err_done_cnt",    32'(bus.ramerr_cnt), 32'd3);
    cyc();
    bus.dREN = 1'b0;
    #1;
    check("err_after_dwait", 32'(bus.dwait),      32'd1);
    check("err_after_cnt",   32'(bus.ramerr_cnt), 32'd3);

    // Asynchronous reset in the middle of a data write grant
    cyc();
    bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'hA5A5A5A5;
    bus.ramstate = BUSY;
    cyc(); #1;
    check("rstmid_pre_ramWEN", 32'(bus.ramWEN), 32'd1);
    #1; RST = 1'b1; #1;
    check("rstmid_ramWEN",  32'(bus.ramWEN),     32'd0);
    check("rstmid_ramREN",  32'(bus.ramREN),     32'd0);
    check("rstmid_dwait",   32'(bus.dwait),      32'd1);
    check("rstmid_ramaddr", bus.ramaddr,         32'd0);
    check("rstmid_errcnt",  32'(bus.ramerr_cnt), 32'd0);
    bus.dWEN = 1'b0; bus.ramstate = ACCESS;
    cyc();
    RST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h400; bus.ramload = 32'h11112222;
    #1;
    check("rstmid_idle_iwait", 32'(bus.iwait), 32'd1);
    cyc(); #1;
    check("rstmid_i_iwait",   32'(bus.iwait),  32'd0);
    check("rstmid_i_iload",   bus.iload,       32'h11112222);
    check("rstmid_i_ramaddr", bus.ramaddr,     32'h400);
    check("rstmid_i_ramREN",  32'(bus.ramREN), 32'd1);
    cyc();
    bus.iREN = 1'b0;

    // Data requester withdraws while RAM is BUSY
    cyc();
    bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = BUSY;
    cyc(); #1;
    check("drop_g1_ramREN", 32'(bus.ramREN), 32'd1);
    check("drop_g1_dwait",  32'(bus.dwait),  32'd1);
    cyc(); #1;
    check("drop_g2_ramREN", 32'(bus.ramREN), 32'd1);
    bus.dREN = 1'b0;
    #1;
    check("drop_now_ramREN",  32'(bus.ramREN), 32'd0);
    check("drop_now_ramaddr", bus.ramaddr,     32'd0);
    check("drop_now_dwait",   32'(bus.dwait),  32'd1);
    cyc();
    bus.ramstate = ACCESS;
    #1;
    check("drop_idle_dwait",  32'(bus.dwait),  32'd1);
    check("drop_idle_ramREN", 32'(bus.ramREN), 32'd0);
    check("drop_idle_dload",  bus.dload,       32'd0);
    cyc(); #1;
    check("drop_idle2_dwait", 32'(bus.dwait), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory controller sitting between the instruction cache, the data cache and main RAM. It is the responder side of the cache request/wait protocol: it accepts word requests from both caches, arbitrates with data-side priority plus an instruction-starvation bound, drives one RAM transaction at a time, and returns load data and wait status to the granted requester. One word is transferred per grant.

## Interface
Parameters:
- STARVE_MAX, 4, max consecutive data grants while an instruction request is pending; range 1-15
- ERRCNT_W, 8, width of the saturating RAM error counter

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  32  instruction word address
- iwait  out  1  low for exactly the cycle iload is valid
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data word address
- dstore  in  32  data write value
- dwait  out  1  low for exactly the cycle of data completion
- dload  out  32  data read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ramerr_cnt  out  ERRCNT_W  saturating count of ERROR cycles seen during grants

## Operation
- States: IDLE, GRANT_D, GRANT_I.
- IDLE: no RAM strobes. Data request = dREN|dWEN. If data request and not (starve_hit and iREN) -> GRANT_D; else if iREN -> GRANT_I; else stay.
- starve_hit = (dstreak == STARVE_MAX).
- GRANT_D: ramaddr=daddr; dWEN set -> ramWEN=1, ramstore=dstore; else ramREN=1. dREN and dWEN together: treated as write.
- GRANT_I: ramREN=1, ramaddr=iaddr.
- In either grant: ramstate==ACCESS -> owner wait=0, owner load=ramload (dload=ramload for data reads only), next IDLE. FREE/BUSY -> hold. ERROR -> hold, reissue next cycle, ramerr_cnt+1 (saturates at all-ones).
- Owner drops its request mid-grant -> strobes deasserted that cycle, next IDLE, no completion.
- dstreak (4 bits): +1 on each GRANT_D entry while iREN=1; cleared on GRANT_I entry or any IDLE cycle with iREN=0.
- Non-owner wait stays 1; non-owner load is 0.

## Timing
- Reset values: state IDLE, dstreak 0, ramerr_cnt 0, iwait=1, dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Reset mid-grant: outputs reach reset values asynchronously; transaction abandoned, no completion.
- Grant registered: request seen in IDLE cycle N, strobes driven from cycle N+1.
- Wait/load are combinational from state and ramstate; ram strobes/addr combinational from state and owner inputs.
- Minimum latency: 2 cycles request-to-completion (RAM ACCESS on first grant cycle). RAM latency L adds L-1.
- After each completion one IDLE cycle always occurs; back-to-back requests are re-arbitrated, so an instruction word may interleave between the two words of a data block.
- Simultaneous iREN and data request, dstreak<STARVE_MAX: data wins.

## Structure
- cpu_types_pkg: word_t, ramstate_t (FREE/BUSY/ACCESS/ERROR). Arbiter state enum stays local.
- No sub-module; starvation counter and error counter are inline registers.

## Test plan
- Data read 0x40, RAM ACCESS on first grant cycle, ramload=0xDEADBEEF -> dwait low in cycle 2, dload=0xDEADBEEF, ramREN=1 ramWEN=0.
- Simultaneous iREN(0x100) and dWEN(0x200, 0x12345678), STARVE_MAX=4 -> data first, ramWEN with 0x200/0x12345678; then instruction grant, iwait low with iload=ramload.
- Data requests held continuously with iREN=1 -> exactly 4 data completions, then one instruction completion, then data resumes.
- RAM returns ERROR for 3 cycles then ACCESS -> strobes held throughout, ramerr_cnt=3, single completion.
- RST asserted mid GRANT_D with RAM BUSY -> ramREN/ramWEN 0 and dwait=1 immediately; after release, new iREN granted normally.
- dREN dropped during BUSY -> strobes drop same cycle, dwait never low, state returns IDLE.
